// File: rtl/hsv_pkg.sv
// Shared definitions for the RGB to HSV stream converter.
// Holds the hue sector encoding, the hue offset helpers and the pipeline
// latency helper, all as functions of the channel width.
package hsv_pkg;

    // Sector = which channel supplied the maximum (R beats G beats B on ties)
    typedef enum logic [1:0] {
        SEC_R = 2'd0,
        SEC_G = 2'd1,
        SEC_B = 2'd2
    } sector_e;

    // Hue offset of the green sector: one third of full scale
    function automatic int unsigned off_g(input int unsigned cw);
        return ((32'd1 << cw) - 32'd1) / 32'd3;
    endfunction

    // Hue offset of the blue sector: two thirds of full scale
    function automatic int unsigned off_b(input int unsigned cw);
        return 32'd2 * off_g(cw);
    endfunction

    // Enabled edges from input sample to registered result
    function automatic int unsigned lat(input int unsigned cw);
        return cw + 32'd3;
    endfunction

endpackage

// File: rtl/div_pipe.sv
// Pipelined restoring divider, one quotient bit resolved per stage.
// The caller guarantees that num/den fits in QW bits. With den=0 the
// quotient saturates to all ones; callers mask that case themselves.
// Ports:
//   clk_i  clock
//   ce_i   advance enable, low freezes every stage
//   num_i  numerator (NW bits)
//   den_i  divisor (DW bits)
//   quo_o  floor(num/den), valid QW enabled edges after num_i/den_i
module div_pipe #(
    parameter int unsigned NW = 16,
    parameter int unsigned DW = 11,
    parameter int unsigned QW = 8
) (
    input  logic          clk_i,
    input  logic          ce_i,
    input  logic [NW-1:0] num_i,
    input  logic [DW-1:0] den_i,
    output logic [QW-1:0] quo_o
);

    localparam int unsigned TW = NW + DW + QW;

    // Remainder and divisor are only carried into stages that still need them
    logic [NW-1:0] rem_q [QW-1];
    logic [NW-1:0] rem_d [QW-1];
    logic [DW-1:0] den_q [QW-1];
    logic [DW-1:0] den_d [QW-1];
    logic [QW-1:0] quo_q [QW];
    logic [QW-1:0] quo_d [QW];

    // Does den shifted left by sh fit into the partial remainder?
    function automatic logic fits(input logic [NW-1:0] rem, input logic [DW-1:0] den,
                                  input int unsigned sh);
        return TW'(rem) >= (TW'(den) << sh);
    endfunction

    function automatic logic [NW-1:0] shl(input logic [DW-1:0] den, input int unsigned sh);
        return NW'(TW'(den) << sh);
    endfunction

    // Per-stage trial subtraction, MSB first
    always_comb begin
        rem_d = rem_q;
        den_d = den_q;
        quo_d = quo_q;

        den_d[0] = den_i;
        if (fits(num_i, den_i, QW - 1)) begin
            rem_d[0] = num_i - shl(den_i, QW - 1);
            quo_d[0] = QW'(1) << (QW - 1);
        end else begin
            rem_d[0] = num_i;
            quo_d[0] = '0;
        end

        for (int unsigned k = 1; k < QW - 1; k++) begin
            den_d[k] = den_q[k-1];
            if (fits(rem_q[k-1], den_q[k-1], QW - 1 - k)) begin
                rem_d[k] = rem_q[k-1] - shl(den_q[k-1], QW - 1 - k);
                quo_d[k] = quo_q[k-1] | (QW'(1) << (QW - 1 - k));
            end else begin
                rem_d[k] = rem_q[k-1];
                quo_d[k] = quo_q[k-1];
            end
        end

        quo_d[QW-1] = quo_q[QW-2] | QW'(fits(rem_q[QW-2], den_q[QW-2], 0));
    end

    // Stage registers, data only (valid tracking lives in the caller)
    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            rem_q <= rem_d;
            den_q <= den_d;
            quo_q <= quo_d;
        end
    end

    assign quo_o = quo_q[QW-1];

endmodule

// File: rtl/rgb2hsv_stream.sv
// Streaming RGB to HSV converter, one pixel per enabled cycle, fixed latency
// of CW+3 enabled edges, no backpressure.
// Ports:
//   clock, reset       clock and synchronous active-high reset
//   ce                 pipeline advance enable, low freezes everything
//   in_valid,r,g,b     input pixel, in_user is its sideband tag
//   out_valid,h,s,v    result, grey flags max==min (h and s forced to 0)
//   out_user           tag of the same pixel
module rgb2hsv_stream
    import hsv_pkg::*;
#(
    parameter int unsigned CW = 8,
    parameter int unsigned UW = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          in_valid,
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] g,
    input  logic [CW-1:0] b,
    input  logic [UW-1:0] in_user,
    output logic          out_valid,
    output logic [CW-1:0] h,
    output logic [CW-1:0] s,
    output logic [CW-1:0] v,
    output logic          grey,
    output logic [UW-1:0] out_user
);

    localparam int unsigned NW = 2 * CW;
    localparam int unsigned DW = CW + 3;
    localparam int unsigned DS = lat(CW) - 3;
    localparam logic [NW-1:0] FULL_N  = NW'((32'd1 << CW) - 32'd1);
    localparam logic [CW-1:0] OFF_G_C = CW'(off_g(CW));
    localparam logic [CW-1:0] OFF_B_C = CW'(off_b(CW));

    // S1: input registers
    logic          s1_vld_q;
    logic [CW-1:0] s1_r_q, s1_g_q, s1_b_q;
    logic [UW-1:0] s1_usr_q;

    always_ff @(posedge clock) begin
        if (reset)   s1_vld_q <= 1'b0;
        else if (ce) s1_vld_q <= in_valid;
    end

    always_ff @(posedge clock) begin
        if (ce) begin
            s1_r_q   <= r;
            s1_g_q   <= g;
            s1_b_q   <= b;
            s1_usr_q <= in_user;
        end
    end

    // S2: max (with sector) and min
    sector_e       s2_sec_d, s2_sec_q;
    logic [CW-1:0] s2_max_d, s2_min_d, s2_max_q, s2_min_q;
    logic [CW-1:0] s2_r_q, s2_g_q, s2_b_q;
    logic          s2_vld_q;
    logic [UW-1:0] s2_usr_q;

    always_comb begin
        s2_sec_d = SEC_B;
        s2_max_d = s1_b_q;
        if (s1_r_q >= s1_g_q && s1_r_q >= s1_b_q) begin
            s2_sec_d = SEC_R;
            s2_max_d = s1_r_q;
        end else if (s1_g_q >= s1_b_q) begin
            s2_sec_d = SEC_G;
            s2_max_d = s1_g_q;
        end
        s2_min_d = s1_r_q;
        if (s1_g_q < s2_min_d) s2_min_d = s1_g_q;
        if (s1_b_q < s2_min_d) s2_min_d = s1_b_q;
    end

    always_ff @(posedge clock) begin
        if (reset)   s2_vld_q <= 1'b0;
        else if (ce) s2_vld_q <= s1_vld_q;
    end

    always_ff @(posedge clock) begin
        if (ce) begin
            s2_sec_q <= s2_sec_d;
            s2_max_q <= s2_max_d;
            s2_min_q <= s2_min_d;
            s2_r_q   <= s1_r_q;
            s2_g_q   <= s1_g_q;
            s2_b_q   <= s1_b_q;
            s2_usr_q <= s1_usr_q;
        end
    end

    // S3: delta, signed hue difference, divider operands
    logic [CW-1:0] s3_delta_d, s3_abs_d;
    logic [CW:0]   s3_diff_d;
    logic          s3_neg_d;

    always_comb begin
        s3_delta_d = s2_max_q - s2_min_q;
        case (s2_sec_q)
            SEC_R:   s3_diff_d = {1'b0, s2_g_q} - {1'b0, s2_b_q};
            SEC_G:   s3_diff_d = {1'b0, s2_b_q} - {1'b0, s2_r_q};
            default: s3_diff_d = {1'b0, s2_r_q} - {1'b0, s2_g_q};
        endcase
        s3_neg_d = s3_diff_d[CW];
        s3_abs_d = s3_neg_d ? CW'(-s3_diff_d) : s3_diff_d[CW-1:0];
    end

    logic          s3_vld_q, s3_neg_q, s3_grey_q;
    sector_e       s3_sec_q;
    logic [CW-1:0] s3_v_q;
    logic [UW-1:0] s3_usr_q;
    logic [NW-1:0] s3_num_h_q, s3_num_s_q;
    logic [DW-1:0] s3_den_h_q;
    logic [CW-1:0] s3_den_s_q;

    always_ff @(posedge clock) begin
        if (reset)   s3_vld_q <= 1'b0;
        else if (ce) s3_vld_q <= s2_vld_q;
    end

    always_ff @(posedge clock) begin
        if (ce) begin
            s3_sec_q   <= s2_sec_q;
            s3_neg_q   <= s3_neg_d;
            s3_grey_q  <= (s3_delta_d == '0);
            s3_v_q     <= s2_max_q;
            s3_usr_q   <= s2_usr_q;
            s3_num_h_q <= NW'(s3_abs_d) * FULL_N;
            s3_den_h_q <= DW'(s3_delta_d) * DW'(3'd6);
            s3_num_s_q <= NW'(s3_delta_d) * FULL_N;
            s3_den_s_q <= s2_max_q;
        end
    end

    // S4..S(CW+3): dividers
    logic [DS-1:0] q_h, q_s;

    div_pipe #(.NW(NW), .DW(DW), .QW(DS)) u_div_hue (
        .clk_i (clock),
        .ce_i  (ce),
        .num_i (s3_num_h_q),
        .den_i (s3_den_h_q),
        .quo_o (q_h)
    );

    div_pipe #(.NW(NW), .DW(CW), .QW(DS)) u_div_sat (
        .clk_i (clock),
        .ce_i  (ce),
        .num_i (s3_num_s_q),
        .den_i (s3_den_s_q),
        .quo_o (q_s)
    );

    // Sideband delay line matching the divider depth
    logic [DS-1:0] dv_vld_q, dv_neg_q, dv_grey_q;
    sector_e       dv_sec_q [DS];
    logic [CW-1:0] dv_v_q   [DS];
    logic [UW-1:0] dv_usr_q [DS];

    always_ff @(posedge clock) begin
        if (reset)   dv_vld_q <= '0;
        else if (ce) dv_vld_q <= {dv_vld_q[DS-2:0], s3_vld_q};
    end

    always_ff @(posedge clock) begin
        if (ce) begin
            dv_neg_q    <= {dv_neg_q[DS-2:0], s3_neg_q};
            dv_grey_q   <= {dv_grey_q[DS-2:0], s3_grey_q};
            dv_sec_q[0] <= s3_sec_q;
            dv_v_q[0]   <= s3_v_q;
            dv_usr_q[0] <= s3_usr_q;
            for (int unsigned i = 1; i < DS; i++) begin
                dv_sec_q[i] <= dv_sec_q[i-1];
                dv_v_q[i]   <= dv_v_q[i-1];
                dv_usr_q[i] <= dv_usr_q[i-1];
            end
        end
    end

    // Output stage: sector offset plus/minus quotient, wrapping mod 2^CW
    logic [CW-1:0] off_d, h_d, s_d;

    always_comb begin
        off_d = '0;
        h_d   = '0;
        s_d   = '0;
        case (dv_sec_q[DS-1])
            SEC_G:   off_d = OFF_G_C;
            SEC_B:   off_d = OFF_B_C;
            default: off_d = '0;
        endcase
        if (!dv_grey_q[DS-1]) begin
            h_d = dv_neg_q[DS-1] ? off_d - CW'(q_h) : off_d + CW'(q_h);
            s_d = CW'(q_s);
        end
    end

    // Payload only loads with a valid result so it holds between results
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            h         <= '0;
            s         <= '0;
            v         <= '0;
            grey      <= 1'b0;
            out_user  <= '0;
        end else if (ce) begin
            out_valid <= dv_vld_q[DS-1];
            if (dv_vld_q[DS-1]) begin
                h        <= h_d;
                s        <= s_d;
                v        <= dv_v_q[DS-1];
                grey     <= dv_grey_q[DS-1];
                out_user <= dv_usr_q[DS-1];
            end
        end
    end

endmodule

// File: tb/tb_rgb2hsv_stream.sv
// Scoreboard bench for rgb2hsv_stream: stimulus pushes expected results,
// a monitor pops them on the enabled edge where they are due.
module tb_rgb2hsv_stream;

    localparam int CW   = 8;
    localparam int UW   = 16;
    localparam int LAT  = CW + 3;
    localparam int MAXV = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset, ce, in_valid;
    logic [CW-1:0] r, g, b;
    logic [UW-1:0] in_user;
    logic          out_valid;
    logic [CW-1:0] h, s, v;
    logic          grey;
    logic [UW-1:0] out_user;

    rgb2hsv_stream #(.CW(CW), .UW(UW)) dut (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .in_valid (in_valid),
        .r        (r),
        .g        (g),
        .b        (b),
        .in_user  (in_user),
        .out_valid(out_valid),
        .h        (h),
        .s        (s),
        .v        (v),
        .grey     (grey),
        .out_user (out_user)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CW-1:0] h, s, v;
        logic          grey;
        logic [UW-1:0] user;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   en_cnt   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t hand(input int hh, input int ss, input int vv, input int gr);
        exp_t e;
        e.h = CW'(hh); e.s = CW'(ss); e.v = CW'(vv); e.grey = 1'(gr);
        e.user = '0; e.due = 0;
        return e;
    endfunction

    // Reference: HSV straight from the integer definitions
    function automatic exp_t model(input int rr, input int gg, input int bb);
        exp_t e;
        int mx, mn, dl, diff, q, hv, sec;
        if (rr >= gg && rr >= bb) begin mx = rr; sec = 0; diff = gg - bb; end
        else if (gg >= bb)        begin mx = gg; sec = 1; diff = bb - rr; end
        else                      begin mx = bb; sec = 2; diff = rr - gg; end
        mn = rr;
        if (gg < mn) mn = gg;
        if (bb < mn) mn = bb;
        dl = mx - mn;
        e.v = CW'(mx); e.user = '0; e.due = 0;
        if (dl == 0) begin
            e.h = '0; e.s = '0; e.grey = 1'b1;
        end else begin
            e.grey = 1'b0;
            e.s = CW'(dl * MAXV / mx);
            q  = (diff < 0 ? -diff : diff) * MAXV / (6 * dl);
            hv = sec * (MAXV / 3) + (diff < 0 ? -q : q);
            hv = ((hv % (MAXV + 1)) + (MAXV + 1)) % (MAXV + 1);
            e.h = CW'(hv);
        end
        return e;
    endfunction

    task automatic step(input logic c, input logic vl, input logic [CW-1:0] rr,
                        input logic [CW-1:0] gg, input logic [CW-1:0] bb,
                        input logic [UW-1:0] u, input exp_t e);
        exp_t t;
        @(negedge clock);
        reset = 1'b0; ce = c; in_valid = vl;
        r = rr; g = gg; b = bb; in_user = u;
        if (c && vl) begin
            t = e; t.user = u; t.due = en_cnt + 1 + LAT;
            sb.push_back(t);
        end
    endtask

    task automatic rand_pixel(input logic c, input logic [UW-1:0] u);
        logic [CW-1:0] rr, gg, bb;
        rr = CW'($urandom_range(0, MAXV));
        gg = ($urandom_range(0, 7) == 0) ? rr : CW'($urandom_range(0, MAXV));
        bb = ($urandom_range(0, 7) == 0) ? gg : CW'($urandom_range(0, MAXV));
        step(c, 1'b1, rr, gg, bb, u, model(int'(rr), int'(gg), int'(bb)));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, '0, '0, hand(0, 0, 0, 0));
    endtask

    // Monitor: one decision per edge, based on ce/reset sampled at that edge
    initial begin : monitor
        logic        ce_s, rst_s;
        logic [41:0] prev, cur;
        exp_t        e;
        prev = '0;
        forever begin
            @(posedge clock);
            ce_s = ce; rst_s = reset;
            #1;
            cur = {out_valid, h, s, v, grey, out_user};
            if (rst_s) begin
                check("reset_valid", 64'(out_valid), 64'(0));
                check("reset_payload", 64'({h, s, v, grey, out_user}), 64'(0));
            end else if (ce_s) begin
                en_cnt++;
                if (sb.size() > 0 && sb[0].due == en_cnt) begin
                    e = sb.pop_front();
                    check("out_valid", 64'(out_valid), 64'(1));
                    check("h", 64'(h), 64'(e.h));
                    check("s", 64'(s), 64'(e.s));
                    check("v", 64'(v), 64'(e.v));
                    check("grey", 64'(grey), 64'(e.grey));
                    check("out_user", 64'(out_user), 64'(e.user));
                end else begin
                    check("idle_valid", 64'(out_valid), 64'(0));
                end
            end else begin
                check("stall_hold", 64'(cur), 64'(prev));
            end
            prev = cur;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, %0d outputs outstanding", sb.size());
        $fatal(1);
    end

    initial begin : stimulus
        int idx;
        logic c;
        reset = 1'b1; ce = 1'b0; in_valid = 1'b0;
        r = '0; g = '0; b = '0; in_user = '0;
        repeat (3) @(negedge clock);

        // Directed corner pixels with hand-derived results
        step(1'b1, 1'b1, 8'd255, 8'd0,   8'd0,   16'd1, hand(0,   255, 255, 0));
        step(1'b1, 1'b1, 8'd0,   8'd255, 8'd0,   16'd2, hand(85,  255, 255, 0));
        step(1'b1, 1'b1, 8'd0,   8'd0,   8'd255, 16'd3, hand(170, 255, 255, 0));
        step(1'b1, 1'b1, 8'd255, 8'd0,   8'd128, 16'd4, hand(235, 255, 255, 0));
        step(1'b1, 1'b1, 8'd100, 8'd100, 8'd100, 16'd5, hand(0,   0,   100, 1));
        step(1'b1, 1'b1, 8'd0,   8'd0,   8'd0,   16'd6, hand(0,   0,   0,   1));
        step(1'b1, 1'b1, 8'd200, 8'd200, 8'd50,  16'd7, hand(42,  191, 200, 0));
        drain(LAT + 2);

        // Reset in the middle of a stream discards everything in flight
        for (int i = 0; i < 5; i++) rand_pixel(1'b1, UW'(16'h100 + i));
        @(negedge clock);
        reset = 1'b1; ce = 1'b0; in_valid = 1'b1;
        sb.delete();
        for (int i = 0; i < 20; i++) rand_pixel(1'b1, UW'(16'h200 + i));
        drain(LAT + 2);

        // Random back-to-back stream with ce low about 30% of cycles
        idx = 0;
        while (idx < 1000) begin
            c = ($urandom_range(0, 99) >= 30);
            rand_pixel(c, UW'(idx));
            if (c) idx++;
        end
        drain(LAT + 3);
        @(negedge clock);

        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb2hsv_stream.md
RGB2HSV_STREAM -- requirements
Module: rgb2hsv_stream

Interface
REQ-001 SHALL have parameter CW, default 8, meaning width of each colour channel and of h/s/v; legal range 4..12.
REQ-002 SHALL have parameter UW, default 1, meaning width of the sideband tag carried alongside each pixel.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port `ce`, input, 1 bit: pipeline advance enable; low freezes every pipeline register.
REQ-007 SHALL have port `in_valid`, input, 1 bit: r/g/b/in_user carry a pixel this cycle.
REQ-008 SHALL have ports `r`, `g`, `b`, input, CW bits each: unsigned colour channels.
REQ-009 SHALL have port `in_user`, input, UW bits: tag, e.g. pixel coordinate, returned unchanged with the result.
REQ-010 SHALL have port `out_valid`, output, 1 bit: h/s/v/grey/out_user hold a result.
REQ-011 SHALL have ports `h`, `s`, `v`, output, CW bits each: hue, saturation, value.
REQ-012 SHALL have port `grey`, output, 1 bit: max equals min, so hue is undefined and h is forced to 0.
REQ-013 SHALL have port `out_user`, output, UW bits: in_user of the same pixel.

Function
REQ-014 SHALL be fully pipelined, accepting one pixel per cycle in which ce=1, with no backpressure.
REQ-015 SHALL have fixed latency LAT = CW+3 enabled edges: pixel sampled at enabled edge t appears on the outputs after enabled edge t+LAT (11 for CW=8).
REQ-016 SHALL use this stage map: S1 register inputs; S2 max/min; S3 delta, numerators, divisors, sector; S4..S(CW+3) divider, one quotient bit per stage; last stage applies hue offset/wrap and registers outputs.
REQ-017 SHALL select max with priority R>G>B when channels tie; v = max.
REQ-018 SHALL compute s = floor((max-min)*(2^CW-1)/max), with s=0 when max=0 and no division by zero.
REQ-019 SHALL compute hue numerator as |diff|*(2^CW-1), where diff is g-b (R sector), b-r (G sector) or r-g (B sector); divisor is 6*delta; q = floor(numerator/divisor), which is at most CW bits.
REQ-020 SHALL use hue offsets OFF_R=0, OFF_G=(2^CW-1)/3 (integer division), OFF_B=2*OFF_G, giving 0/85/170 for CW=8.
REQ-021 SHALL output h = (offset+q) mod 2^CW when diff>=0, and h = (offset-q) mod 2^CW when diff<0 (wraps, e.g. 0-21 gives 235).
REQ-022 SHALL output h=0, s=0, grey=1 when delta=0; grey=0 otherwise.
REQ-023 SHALL have every quotient truncate (floor) with no rounding.
REQ-024 SHALL carry valid and in_user through the same number of stages as the data; out_user always aligns with its pixel.
REQ-025 SHALL, while ce=0, hold all stages and outputs unchanged, including out_valid; no pixel is lost or duplicated across a stall.
REQ-026 SHALL have outputs h/s/v/grey/out_user hold their last value while out_valid=0; only out_valid qualifies them.

Reset
REQ-027 SHALL, on reset high at an edge, clear all valid bits; out_valid, h, s, v, grey and out_user are 0 after that edge.
REQ-028 SHALL have reset override ce; data-path registers other than the outputs need no reset.
REQ-029 SHALL discard all in-flight pixels on reset mid-stream; out_valid stays 0 until LAT enabled edges after the first post-reset accepted pixel.

Structure
REQ-030 SHALL place in shared package hsv_pkg: OFF_G/OFF_B as functions of CW, the LAT function, and the sector encoding constants (SEC_R, SEC_G, SEC_B).
REQ-031 SHALL implement the dividers in one sub-module div_pipe (parameters NW, DW, QW; pipelined restoring division, one stage per quotient bit, ce-gated), instantiated twice (hue, saturation).
REQ-032 SHALL keep the sideband/valid delay inside rgb2hsv_stream, not in div_pipe.

Verification
REQ-033 SHALL check, with CW=8 and ce=1: r=255 g=0 b=0 -> after 11 edges h=0 s=255 v=255 grey=0.
REQ-034 SHALL check r=0 g=255 b=0 -> h=85; r=0 g=0 b=255 -> h=170; both s=255 v=255.
REQ-035 SHALL check r=255 g=0 b=128 -> h=235 s=255 v=255 (negative wrap).
REQ-036 SHALL check r=g=b=100 -> h=0 s=0 v=100 grey=1; r=g=b=0 -> h=0 s=0 v=0 grey=1.
REQ-037 SHALL check 1000 back-to-back random pixels with in_user=index and ce randomly low 30% of cycles -> every output matches the bit-exact model, out_user in order, none lost or duplicated.
REQ-038 SHALL check reset pulsed at cycle 5 of a stream -> out_valid=0 next cycle and for LAT cycles after streaming resumes; first output equals first post-reset pixel.
